// File: rtl/idma_be_share_arb_pkg.sv
// Shared defaults and width helpers for the iDMA backend share arbiter.
// Optional statistics are enabled by IDMA_BE_SHARE_ARB_STATS_EN (see top).
package idma_be_share_arb_pkg;

    localparam int unsigned DefNumReq       = 2;
    localparam int unsigned DefBackendDepth = 5;

    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/idma_be_share_arb_if.sv
// Frontend/backend handshake bundle of the share arbiter.
// slave = arbiter side, master = surrounding wrap / testbench side.
interface idma_be_share_arb_if
    import idma_be_share_arb_pkg::*;
#(
    parameter int unsigned NumReq   = DefNumReq,
    parameter int unsigned CntWidth = cnt_width(DefBackendDepth),
    parameter type         req_t    = logic,
    parameter type         rsp_t    = logic
);
    req_t                fe_req_i [NumReq];
    logic [NumReq-1:0]   fe_req_valid_i;
    logic [NumReq-1:0]   fe_req_ready_o;
    rsp_t                fe_rsp_o [NumReq];
    logic [NumReq-1:0]   fe_rsp_valid_o;
    logic [NumReq-1:0]   fe_rsp_ready_i;
    req_t                be_req_o;
    logic                be_req_valid_o;
    logic                be_req_ready_i;
    rsp_t                be_rsp_i;
    logic                be_rsp_valid_i;
    logic                be_rsp_ready_o;
    logic [CntWidth-1:0] outstanding_o;
    logic [NumReq-1:0]   busy_o;

    modport slave (
        input  fe_req_i, fe_req_valid_i, fe_rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
        output fe_req_ready_o, fe_rsp_o, fe_rsp_valid_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
               outstanding_o, busy_o
    );

    modport master (
        output fe_req_i, fe_req_valid_i, fe_rsp_ready_i, be_req_ready_i, be_rsp_i, be_rsp_valid_i,
        input  fe_req_ready_o, fe_rsp_o, fe_rsp_valid_o, be_req_o, be_req_valid_o, be_rsp_ready_o,
               outstanding_o, busy_o
    );
endinterface

// File: rtl/idma_be_share_arb_order_fifo.sv
// Requester-index FIFO recording backend issue order; head is combinational from storage.
// Latency: push visible at head next cycle. Push ignored when full, pop ignored when empty.
module idma_be_share_arb_order_fifo #(
    parameter int unsigned Depth     = 5,
    parameter int unsigned DataWidth = 1,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DataWidth-1:0] head_o,
    output logic [CntWidth-1:0]  count_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic                 do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/idma_be_share_arb.sv
// Shares one iDMA backend between NumReq frontends: round-robin issue, responses steered by issue order.
// Latency: 0-cycle request pass-through; grant locks while backend stalls; issue blocked at BackendDepth outstanding.
// Macro IDMA_BE_SHARE_ARB_STATS_EN adds per-requester grant counters (stat_grants_o, stat_clear_i).
module idma_be_share_arb
    import idma_be_share_arb_pkg::*;
#(
    parameter int unsigned NumReq       = DefNumReq,
    parameter int unsigned BackendDepth = DefBackendDepth,
    parameter type         idma_req_t   = logic,
    parameter type         idma_rsp_t   = logic,
    parameter int unsigned IdxWidth     = idx_width(NumReq),
    parameter int unsigned CntWidth     = cnt_width(BackendDepth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    idma_be_share_arb_if.slave  bus
`ifdef IDMA_BE_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grants_o [NumReq],
    input  logic                stat_clear_i
`endif
);
    logic [IdxWidth-1:0] rr_q, rr_d;          // first index searched next
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [CntWidth-1:0] cnt_q [NumReq];
    logic [CntWidth-1:0] cnt_d [NumReq];

    logic [IdxWidth-1:0] gnt_idx, cand, head_idx;
    logic                gnt_any, be_req_vld, push, pop, fifo_full, fifo_empty, be_rsp_rdy;
    logic [NumReq-1:0]   fe_req_rdy, fe_rsp_vld;
    logic [CntWidth-1:0] fifo_count;
    idma_req_t           gnt_req;
    idma_rsp_t           rsp_bcast;

    always_comb begin
        gnt_any = lock_q;
        gnt_idx = lock_idx_q;
        cand    = '0;
        if (!lock_q) begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = IdxWidth'((32'(rr_q) + k) % NumReq);
                if (!gnt_any && bus.fe_req_valid_i[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign gnt_req    = bus.fe_req_i[gnt_idx];
    assign be_req_vld = gnt_any && !fifo_full;
    assign push       = be_req_vld && bus.be_req_ready_i;
    assign be_rsp_rdy = !fifo_empty && bus.fe_rsp_ready_i[head_idx];
    assign pop        = bus.be_rsp_valid_i && be_rsp_rdy;
    assign rsp_bcast  = bus.be_rsp_i;

    always_comb begin
        fe_req_rdy = '0;
        fe_rsp_vld = '0;
        if (be_req_vld) fe_req_rdy[gnt_idx] = bus.be_req_ready_i;
        if (!fifo_empty) fe_rsp_vld[head_idx] = bus.be_rsp_valid_i;
        for (int unsigned i = 0; i < NumReq; i++) bus.fe_rsp_o[i] = rsp_bcast;
    end

    assign bus.be_req_o       = gnt_req;
    assign bus.be_req_valid_o = be_req_vld;
    assign bus.fe_req_ready_o = fe_req_rdy;
    assign bus.fe_rsp_valid_o = fe_rsp_vld;
    assign bus.be_rsp_ready_o = be_rsp_rdy;
    assign bus.outstanding_o  = fifo_count;

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        if (push) begin
            lock_d = 1'b0;
            rr_d   = (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + IdxWidth'(1);
        end else if (be_req_vld) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push && gnt_idx == IdxWidth'(i) && !(pop && head_idx == IdxWidth'(i)))
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            else if (pop && head_idx == IdxWidth'(i) && !(push && gnt_idx == IdxWidth'(i)))
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) bus.busy_o[i] = (cnt_q[i] != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int unsigned i = 0; i < NumReq; i++) cnt_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    idma_be_share_arb_order_fifo #(
        .Depth     (BackendDepth),
        .DataWidth (IdxWidth),
        .CntWidth  (CntWidth)
    ) i_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (gnt_idx),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_idx),
        .count_o (fifo_count)
    );

`ifdef IDMA_BE_SHARE_ARB_STATS_EN
    logic [31:0] stat_q [NumReq];
    logic [31:0] stat_d [NumReq];

    // Clear takes priority over a grant in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clear_i) stat_d[i] = '0;
            else if (push && gnt_idx == IdxWidth'(i)) stat_d[i] = stat_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumReq; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grants_o = stat_q;
`endif

`ifndef SYNTHESIS
    rsp_without_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.be_rsp_valid_i && fifo_empty));
`endif
endmodule

// File: tb/tb_idma_be_share_arb.sv
// Randomized + directed bench for idma_be_share_arb against a queue-based issue-order model.
module tb_idma_be_share_arb;
    localparam int N  = 2;
    localparam int D  = 5;
    localparam int CW = 3;
    typedef logic [15:0] req_t;
    typedef logic [15:0] rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    idma_be_share_arb_if #(.NumReq(N), .CntWidth(CW), .req_t(req_t), .rsp_t(rsp_t)) bus ();

`ifdef IDMA_BE_SHARE_ARB_STATS_EN
    logic [31:0] stat_grants [N];
    logic        stat_clear = 1'b0;
`endif

    idma_be_share_arb #(
        .NumReq(N), .BackendDepth(D), .idma_req_t(req_t), .idma_rsp_t(rsp_t)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef IDMA_BE_SHARE_ARB_STATS_EN
        ,
        .stat_grants_o (stat_grants),
        .stat_clear_i  (stat_clear)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of requester indices in issue order, last granted index, held grant.
    int         oq[$];
    int         last_gnt = -1;
    int         locked   = -1;
    logic [N-1:0] m_hs   = '0;

    function automatic int m_gnt();
        if (locked >= 0) return locked;
        for (int i = 1; i <= N; i++) begin
            int r;
            r = (last_gnt + i + N) % N;
            if (bus.fe_req_valid_i[r]) return r;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oq.delete();
            last_gnt = -1;
            locked   = -1;
            m_hs     = '0;
        end else begin
            int g, hd;
            bit vld, push, pop;
            g    = m_gnt();
            vld  = (g >= 0) && (oq.size() < D);
            hd   = (oq.size() > 0) ? oq[0] : -1;
            push = vld && bus.be_req_ready_i;
            pop  = (hd >= 0) && bus.be_rsp_valid_i && bus.fe_rsp_ready_i[hd];
            m_hs = '0;
            if (pop) void'(oq.pop_front());
            if (push) begin
                oq.push_back(g);
                last_gnt = g;
                locked   = -1;
                m_hs[g]  = 1'b1;
            end else if (vld) begin
                locked = g;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            int g, hd;
            bit vld;
            logic [N-1:0] erdy, ersp, ebusy;
            g     = m_gnt();
            vld   = (g >= 0) && (oq.size() < D);
            hd    = (oq.size() > 0) ? oq[0] : -1;
            erdy  = '0;
            ersp  = '0;
            ebusy = '0;
            if (vld) erdy[g] = bus.be_req_ready_i;
            if (hd >= 0) ersp[hd] = bus.be_rsp_valid_i;
            foreach (oq[k]) ebusy[oq[k]] = 1'b1;
            chk("m_be_req_valid", 32'(bus.be_req_valid_o), 32'(vld));
            if (vld) chk("m_be_req_payload", 32'(bus.be_req_o), 32'(bus.fe_req_i[g]));
            chk("m_fe_req_ready", 32'(bus.fe_req_ready_o), 32'(erdy));
            chk("m_fe_rsp_valid", 32'(bus.fe_rsp_valid_o), 32'(ersp));
            chk("m_be_rsp_ready", 32'(bus.be_rsp_ready_o), 32'((hd >= 0) && bus.fe_rsp_ready_i[hd]));
            chk("m_outstanding", 32'(bus.outstanding_o), 32'(oq.size()));
            chk("m_busy", 32'(bus.busy_o), 32'(ebusy));
            for (int i = 0; i < N; i++) chk("m_fe_rsp_data", 32'(bus.fe_rsp_o[i]), 32'(bus.be_rsp_i));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fe_req_valid_i = '0;
        bus.fe_rsp_ready_i = '0;
        bus.be_req_ready_i = 1'b0;
        bus.be_rsp_valid_i = 1'b0;
        bus.be_rsp_i       = '0;
    endtask

    task automatic drain();
        bus.fe_req_valid_i = '0;
        bus.fe_rsp_ready_i = '1;
        for (int k = 0; k < 20 && oq.size() > 0; k++) begin
            bus.be_rsp_valid_i = 1'b1;
            bus.be_rsp_i       = 16'($urandom);
            tick();
        end
        bus.be_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_empty", 32'(bus.outstanding_o), 32'd0);
        tick();
    endtask

    logic [1:0] alt_exp [5];
    logic [1:0] ord_exp [3];

    initial begin
        alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        ord_exp = '{2'b10, 2'b01, 2'b10};
        for (int i = 0; i < N; i++) bus.fe_req_i[i] = '0;
        idle_inputs();
        #2;
        chk("rst_be_req_valid", 32'(bus.be_req_valid_o), 32'd0);
        chk("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_fe_rsp_valid", 32'(bus.fe_rsp_valid_o), 32'd0);
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Alternating grants until the order FIFO fills.
        bus.fe_req_i[0] = 16'hA000;
        bus.fe_req_i[1] = 16'hA001;
        bus.fe_req_valid_i = 2'b11;
        bus.be_req_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("alt_grant", 32'(bus.fe_req_ready_o), 32'(alt_exp[k]));
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_outstanding", 32'(bus.outstanding_o), 32'd5);
            chk("full_no_issue", 32'(bus.be_req_valid_o), 32'd0);
            tick();
        end
        bus.fe_req_valid_i = '0;
        bus.fe_rsp_ready_i = '1;
        bus.be_rsp_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.be_rsp_i = 16'hB000 + 16'(k);
            @(negedge clk);
            chk("alt_rsp_route", 32'(bus.fe_rsp_valid_o), 32'(alt_exp[k]));
            tick();
        end
        bus.be_rsp_valid_i = 1'b0;
        bus.be_req_ready_i = 1'b0;

        // Grant held while the backend stalls; req1 waits for the handshake.
        bus.fe_req_i[0] = 16'hC000;
        bus.fe_req_i[1] = 16'hC001;
        bus.fe_req_valid_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lock_payload", 32'(bus.be_req_o), 32'h0000C000);
            chk("lock_valid", 32'(bus.be_req_valid_o), 32'd1);
            tick();
            bus.fe_req_valid_i = 2'b11;
        end
        bus.be_req_ready_i = 1'b1;
        @(negedge clk);
        chk("lock_release", 32'(bus.fe_req_ready_o), 32'h1);
        tick();
        bus.fe_req_valid_i = 2'b10;
        @(negedge clk);
        chk("after_lock_grant", 32'(bus.fe_req_ready_o), 32'h2);
        chk("after_lock_payload", 32'(bus.be_req_o), 32'h0000C001);
        tick();
        drain();

        // Issue order 1,0,1 then responses routed in that order.
        bus.be_req_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.fe_req_valid_i = ord_exp[k];
            @(negedge clk);
            chk("ord_grant", 32'(bus.fe_req_ready_o), 32'(ord_exp[k]));
            tick();
        end
        bus.fe_req_valid_i = '0;
        bus.be_req_ready_i = 1'b0;
        bus.be_rsp_valid_i = 1'b1;
        bus.fe_rsp_ready_i = 2'b01;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_be_rsp_ready", 32'(bus.be_rsp_ready_o), 32'd0);
            chk("hold_fe_rsp_valid", 32'(bus.fe_rsp_valid_o), 32'h2);
            chk("hold_outstanding", 32'(bus.outstanding_o), 32'd3);
            chk("hold_busy", 32'(bus.busy_o), 32'h3);
            tick();
        end
        bus.fe_rsp_ready_i = 2'b11;
        @(negedge clk);
        chk("rsp0_route", 32'(bus.fe_rsp_valid_o), 32'h2);
        tick();
        @(negedge clk);
        chk("rsp1_busy", 32'(bus.busy_o), 32'h3);
        chk("rsp1_route", 32'(bus.fe_rsp_valid_o), 32'h1);
        tick();
        @(negedge clk);
        chk("rsp2_busy", 32'(bus.busy_o), 32'h2);
        chk("rsp2_route", 32'(bus.fe_rsp_valid_o), 32'h2);
        tick();
        bus.be_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("rsp3_busy", 32'(bus.busy_o), 32'h0);
        tick();

        // Full FIFO: same-cycle response does not free a slot for issue.
        bus.fe_req_valid_i = 2'b11;
        bus.be_req_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.be_rsp_valid_i = 1'b1;
        @(negedge clk);
        chk("fullpp_count", 32'(bus.outstanding_o), 32'd5);
        chk("fullpp_blocked", 32'(bus.be_req_valid_o), 32'd0);
        chk("fullpp_pop", 32'(bus.be_rsp_ready_o), 32'd1);
        tick();
        bus.be_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("fullpp_after_pop", 32'(bus.outstanding_o), 32'd4);
        chk("fullpp_issue", 32'(bus.be_req_valid_o), 32'd1);
        tick();
        @(negedge clk);
        chk("fullpp_refill", 32'(bus.outstanding_o), 32'd5);
        tick();
        drain();

        // Reset with outstanding transfers.
        bus.fe_req_valid_i = 2'b11;
        bus.be_req_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        bus.fe_req_valid_i = '0;
        @(negedge clk);
        chk("prerst_count", 32'(bus.outstanding_o), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("arst_busy", 32'(bus.busy_o), 32'd0);
        chk("arst_be_req_valid", 32'(bus.be_req_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.fe_req_valid_i = 2'b11;
        @(negedge clk);
        chk("postrst_grant", 32'(bus.fe_req_ready_o), 32'h1);
        tick();
        drain();

`ifdef IDMA_BE_SHARE_ARB_STATS_EN
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        bus.be_req_ready_i = 1'b1;
        bus.fe_req_valid_i = 2'b01;
        for (int k = 0; k < 4; k++) tick();
        bus.fe_req_valid_i = '0;
        @(negedge clk);
        chk("stat_req0", stat_grants[0], 32'd4);
        chk("stat_req1", stat_grants[1], 32'd0);
        tick();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        @(negedge clk);
        chk("stat_cleared", stat_grants[0], 32'd0);
        tick();
        drain();
`endif

        // Randomized traffic; frontends hold valid/payload until their handshake.
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.fe_req_valid_i[i] || m_hs[i]) begin
                    bus.fe_req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    bus.fe_req_i[i]       = 16'($urandom);
                end
            end
            bus.be_req_ready_i = ($urandom_range(0, 3) != 0);
            bus.be_rsp_valid_i = (oq.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.be_rsp_i       = 16'($urandom);
            bus.fe_rsp_ready_i = 2'($urandom);
            tick();
        end
        idle_inputs();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/idma_be_share_arb.md
Name: idma_be_share_arb

Overview:
- Shares one iDMA backend request/response port between NumReq frontends, e.g. several desc64 frontends or a desc64 frontend plus a register frontend.
- Arbitrates 1-D transfer requests round-robin and records the issue order in an order FIFO.
- Steers each backend response back to the requester that issued the matching transfer.
- Sits between the frontends and the backend instance inside a top-level wrap.

Parameters:
- NumReq, 2, number of requesting frontends (≥2).
- BackendDepth, 5, max transfers outstanding in the backend; order FIFO depth.
- idma_req_t, logic, backend request type (IDMA_TYPEDEF_FULL_REQ_T).
- idma_rsp_t, logic, backend response type (IDMA_TYPEDEF_FULL_RSP_T).
- IdxWidth, max(1,$clog2(NumReq)), requester index width (do not override).
- CntWidth, $clog2(BackendDepth+1), outstanding count width (do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- fe_req_i  in  NumReq x idma_req_t  per-requester transfer request.
- fe_req_valid_i  in  NumReq  request valid.
- fe_req_ready_o  out  NumReq  request ready.
- fe_rsp_o  out  NumReq x idma_rsp_t  response to each requester.
- fe_rsp_valid_o  out  NumReq  response valid.
- fe_rsp_ready_i  in  NumReq  response ready.
- be_req_o  out  idma_req_t  request to backend.
- be_req_valid_o  out  1  backend request valid.
- be_req_ready_i  in  1  backend request ready.
- be_rsp_i  in  idma_rsp_t  backend response.
- be_rsp_valid_i  in  1  backend response valid.
- be_rsp_ready_o  out  1  backend response ready.
- outstanding_o  out  CntWidth  transfers issued but not yet answered.
- busy_o  out  NumReq  per requester: at least one of its transfers is outstanding.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; RR pointer=0; order FIFO empty; lock cleared.
- Arbitration:
  - Combinational round-robin. Search starts at the index after the last granted requester (index 0 after reset).
  - Grants the first requester with fe_req_valid_i=1.
- Lock:
  - Once be_req_valid_o=1 without be_req_ready_i, the grant index is registered and held.
  - be_req_o stays stable until the handshake, even if a higher-priority requester asserts valid.
  - Lock clears on the handshake.
- Issue gating: be_req_valid_o = (any valid or locked) && count < BackendDepth. The full check uses the registered count, so a pop in the same cycle does not allow a push.
- Only the granted fe_req_ready_o mirrors be_req_ready_i (gated by not-full). All other readies are 0.
- Issue latency: 0 cycles (combinational pass-through of the request payload).
- Handshake on issue: push grant index into order FIFO; RR pointer ← grant index.
- Response steering:
  - head = FIFO head index.
  - fe_rsp_o[all] = be_rsp_i.
  - fe_rsp_valid_o[head] = be_rsp_valid_i && !empty; all others 0.
  - be_rsp_ready_o = fe_rsp_ready_i[head] && !empty.
  - Pop on the response handshake.
- Empty FIFO with be_rsp_valid_i=1: be_rsp_ready_o=0 (response stalls, never dropped). The simulation assertion fires.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo BackendDepth; the depth need not be a power of 2.
- outstanding_o = registered count.
- busy_o[i] = per-requester outstanding counter ≠ 0. Each counter increments on issue and decrements on response; both in the same cycle leaves it unchanged.
- Requests to the backend are serviced in order. Responses therefore return in issue order, and the order FIFO is the sole source of routing.

Optional Feature:
- Macro: IDMA_BE_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_o (NumReq x 32). Each entry counts issue handshakes per requester.
  - Counters wrap at 2^32 and reset to 0.
  - Adds input stat_clear_i (1); when 1, all counters are synchronously zeroed and clear wins over a same-cycle increment.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package idma_be_share_arb_pkg: default widths, plus a function computing IdxWidth.
- Sub-module idma_be_share_arb_order_fifo: index FIFO with push, pop, full, empty, head and a count output. It is the only sequential storage apart from the lock, RR pointer and per-requester counters.
- The RR arbiter stays inline.

Test Plan:
- NumReq=2, both valid continuously, be_req_ready_i=1 -> grants alternate 0,1,0,1; outstanding_o rises to 5 and be_req_valid_o drops while no responses arrive.
- Req0 issued, be_req_ready_i=0 for 3 cycles, req1 raises valid in cycle 1 -> be_req_o stays req0 payload until the handshake; req1 granted in the next cycle.
- Issue order 1,0,1, then 3 backend responses -> fe_rsp_valid_o pulses on 1, 0, 1 in order; busy_o goes from 2'b11 to 2'b10 to 2'b00.
- fe_rsp_ready_i[1]=0 while head=1 -> be_rsp_ready_o=0 and the response is held; count stays 3 until ready.
- FIFO full (5) with a same-cycle issue attempt and response -> issue blocked that cycle, count 4, issue accepted next cycle.
- Reset asserted with 3 outstanding -> all outputs 0 immediately; the first grant after reset goes to requester 0. With STATS_EN: 4 grants to req0 then stat_clear_i -> counter reads 0.
